// File: rtl/stopwatch_bcd.sv
// BCD mm:ss stopwatch advanced by synchronised SLOW_CLK ticks.
// Start/stop and clear buttons are synchronised and edge-detected.
module stopwatch_bcd #(
   parameter int MAX_MIN = 59
) (
   input  logic       sCLK,
   input  logic       RESET,
   input  logic       SLOW_CLK,
   input  logic       BTN_SS,
   input  logic       BTN_CLR,
   output logic [3:0] SEC_ONES,
   output logic [3:0] SEC_TENS,
   output logic [3:0] MIN_ONES,
   output logic [3:0] MIN_TENS,
   output logic       RUNNING,
   output logic       WRAP
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

   // bit 0 tick, bit 1 start/stop, bit 2 clear
   logic [2:0] s1_q, s2_q, prev_q;
   logic [2:0] ev;

   state_t     state_q, state_d;
   logic [3:0] so_q, so_d;
   logic [3:0] st_q, st_d;
   logic [3:0] mo_q, mo_d;
   logic [3:0] mt_q, mt_d;
   logic       run_q, run_d;
   logic       wrap_q, wrap_d;
   logic       tick_ev, ss_ev, clr_ev;
   logic       at_max;

   assign ev      = s2_q & ~prev_q;
   assign tick_ev = ev[0];
   assign ss_ev   = ev[1];
   assign clr_ev  = ev[2];

   always_ff @(posedge sCLK) begin
      if (RESET) begin
         s1_q   <= '0;
         s2_q   <= '0;
         prev_q <= '0;
      end else begin
         s1_q   <= {BTN_CLR, BTN_SS, SLOW_CLK};
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign at_max = (mt_q == MAX_T) && (mo_q == MAX_O) &&
                   (st_q == 4'd5) && (so_q == 4'd9);

   always_comb begin
      state_d = state_q;
      so_d    = so_q;
      st_d    = st_q;
      mo_d    = mo_q;
      mt_d    = mt_q;
      wrap_d  = 1'b0;
      if (clr_ev) begin
         state_d = IDLE;
         so_d    = '0;
         st_d    = '0;
         mo_d    = '0;
         mt_d    = '0;
      end else begin
         // tick qualifies on the pre-edge state, so SS+tick in RUN still counts
         if (tick_ev && state_q == RUN) begin
            if (at_max) begin
               so_d   = '0;
               st_d   = '0;
               mo_d   = '0;
               mt_d   = '0;
               wrap_d = 1'b1;
            end else if (so_q != 4'd9) begin
               so_d = so_q + 4'd1;
            end else begin
               so_d = '0;
               if (st_q != 4'd5) begin
                  st_d = st_q + 4'd1;
               end else begin
                  st_d = '0;
                  if (mo_q != 4'd9) begin
                     mo_d = mo_q + 4'd1;
                  end else begin
                     mo_d = '0;
                     mt_d = mt_q + 4'd1;
                  end
               end
            end
         end
         case (state_q)
            IDLE:    if (ss_ev) state_d = RUN;
            RUN:     if (ss_ev) state_d = PAUSE;
            PAUSE:   if (ss_ev) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
      run_d = (state_d == RUN);
   end

   always_ff @(posedge sCLK) begin
      if (RESET) begin
         state_q <= IDLE;
         so_q    <= '0;
         st_q    <= '0;
         mo_q    <= '0;
         mt_q    <= '0;
         run_q   <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         so_q    <= so_d;
         st_q    <= st_d;
         mo_q    <= mo_d;
         mt_q    <= mt_d;
         run_q   <= run_d;
         wrap_q  <= wrap_d;
      end
   end

   assign SEC_ONES = so_q;
   assign SEC_TENS = st_q;
   assign MIN_ONES = mo_q;
   assign MIN_TENS = mt_q;
   assign RUNNING  = run_q;
   assign WRAP     = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: default instance plus a
// MAX_MIN=2 instance for the wrap case.
module tb_stopwatch_bcd;

   logic sCLK, RESET;
   logic slw, ss, clr;
   logic slw2, ss2, clr2;
   logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
   logic run0, wrap0, run1, wrap1;
   logic [17:0] o0, o1;

   int n_tests = 0;
   int n_fail  = 0;
   int m_sec[2];
   int m_st[2];
   int lim[2] = '{3600, 180};
   logic [17:0] q[$];

   stopwatch_bcd dut (
      .sCLK(sCLK), .RESET(RESET), .SLOW_CLK(slw),
      .BTN_SS(ss), .BTN_CLR(clr),
      .SEC_ONES(so0), .SEC_TENS(st0),
      .MIN_ONES(mo0), .MIN_TENS(mt0),
      .RUNNING(run0), .WRAP(wrap0)
   );

   stopwatch_bcd #(.MAX_MIN(2)) dut2 (
      .sCLK(sCLK), .RESET(RESET), .SLOW_CLK(slw2),
      .BTN_SS(ss2), .BTN_CLR(clr2),
      .SEC_ONES(so1), .SEC_TENS(st1),
      .MIN_ONES(mo1), .MIN_TENS(mt1),
      .RUNNING(run1), .WRAP(wrap1)
   );

   assign o0 = {mt0, mo0, st0, so0, run0, wrap0};
   assign o1 = {mt1, mo1, st1, so1, run1, wrap1};

   initial sCLK = 1'b0;
   always #5 sCLK = ~sCLK;

   function automatic logic [15:0] bcd(input int s);
      int m, c;
      m = s / 60;
      c = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   function automatic logic [17:0] mexp(input int b);
      return {bcd(m_sec[b]), m_st[b] == 1, 1'b0};
   endfunction

   task automatic step();
      @(posedge sCLK);
      #1;
   endtask

   task automatic drv(input int b, input logic s, input logic c,
                      input logic t);
      if (b == 0) begin
         ss = s; clr = c; slw = t;
      end else begin
         ss2 = s; clr2 = c; slw2 = t;
      end
   endtask

   task automatic model(input int b, input bit s, input bit c,
                        input bit t, input bit push);
      bit w;
      w = 1'b0;
      if (c) begin
         m_sec[b] = 0;
         m_st[b]  = 0;
      end else begin
         if (t && m_st[b] == 1) begin
            m_sec[b]++;
            if (m_sec[b] == lim[b]) begin
               m_sec[b] = 0;
               w = 1'b1;
            end
         end
         if (s) m_st[b] = (m_st[b] == 1) ? 2 : 1;
      end
      if (push) q.push_back({bcd(m_sec[b]), m_st[b] == 1, w});
   endtask

   task automatic mreset();
      for (int b = 0; b < 2; b++) begin
         m_sec[b] = 0;
         m_st[b]  = 0;
      end
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      drv(0, 0, 0, 0);
      drv(1, 0, 0, 0);
      step();
      step();
      RESET = 1'b0;
      mreset();
   endtask

   task automatic apply(input int b, input bit s, input bit c,
                        input bit t);
      model(b, s, c, t, 1'b1);
      drv(b, s, c, t);
      step();
      drv(b, 0, 0, 0);
      step();
      step();
   endtask

   task automatic fast(input int b, input int n);
      repeat (n) begin
         model(b, 0, 0, 1, 1'b0);
         drv(b, 0, 0, 1);
         step();
         drv(b, 0, 0, 0);
         step();
      end
      step();
      step();
   endtask

   task automatic test_reset();
      logic [17:0] e;
      do_reset();
      e = 18'h0;
      n_tests++;
      if (o0 !== e) begin
         n_fail++;
         $display("FAIL reset_a got %h exp %h", o0, e);
      end
      n_tests++;
      if (o1 !== e) begin
         n_fail++;
         $display("FAIL reset_b got %h exp %h", o1, e);
      end
   endtask

   task automatic test_count();
      logic [17:0] e, prev;
      do_reset();
      apply(0, 1, 0, 0);
      e = q.pop_front();
      n_tests++;
      if (o0 !== e) begin
         n_fail++;
         $display("FAIL count_start got %h exp %h", o0, e);
      end
      for (int i = 0; i < 5; i++) begin
         prev = {bcd(m_sec[0]), 1'b1, 1'b0};
         model(0, 0, 0, 1, 1'b1);
         drv(0, 0, 0, 1);
         step();
         drv(0, 0, 0, 0);
         step();
         n_tests++;
         if (o0 !== prev) begin
            n_fail++;
            $display("FAIL count_early%0d got %h exp %h", i, o0, prev);
         end
         step();
         e = q.pop_front();
         n_tests++;
         if (o0 !== e) begin
            n_fail++;
            $display("FAIL count_tick%0d got %h exp %h", i, o0, e);
         end
      end
      n_tests++;
      if (o0 !== {16'h0005, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL count_final got %h exp %h", o0,
                  {16'h0005, 1'b1, 1'b0});
      end
   endtask

   task automatic test_carry();
      logic [17:0] e;
      do_reset();
      apply(0, 1, 0, 0);
      void'(q.pop_front());
      fast(0, 59);
      n_tests++;
      if (o0 !== {16'h0059, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL carry_0059 got %h", o0);
      end
      apply(0, 0, 0, 1);
      e = q.pop_front();
      n_tests++;
      if (o0 !== e) begin
         n_fail++;
         $display("FAIL carry_0100 got %h exp %h", o0, e);
      end
      fast(0, 539);
      apply(0, 0, 0, 1);
      e = q.pop_front();
      n_tests++;
      if (o0 !== e || e[17:2] !== 16'h1000) begin
         n_fail++;
         $display("FAIL carry_1000 got %h exp %h", o0, e);
      end
   endtask

   task automatic test_wrap();
      logic [17:0] e;
      do_reset();
      apply(1, 1, 0, 0);
      void'(q.pop_front());
      fast(1, 179);
      e = mexp(1);
      n_tests++;
      if (o1 !== e || e[17:2] !== 16'h0259) begin
         n_fail++;
         $display("FAIL wrap_0259 got %h exp %h", o1, e);
      end
      apply(1, 0, 0, 1);
      e = q.pop_front();
      n_tests++;
      if (o1 !== e || e !== {16'h0000, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL wrap_pulse got %h exp %h", o1, e);
      end
      step();
      e = mexp(1);
      n_tests++;
      if (o1 !== e) begin
         n_fail++;
         $display("FAIL wrap_after got %h exp %h", o1, e);
      end
   endtask

   task automatic test_pause();
      logic [17:0] e;
      do_reset();
      apply(0, 1, 0, 0);
      void'(q.pop_front());
      fast(0, 3);
      apply(0, 1, 0, 0);
      e = q.pop_front();
      n_tests++;
      if (o0 !== e) begin
         n_fail++;
         $display("FAIL pause_stop got %h exp %h", o0, e);
      end
      for (int i = 0; i < 4; i++) begin
         apply(0, 0, 0, 1);
         e = q.pop_front();
         n_tests++;
         if (o0 !== e) begin
            n_fail++;
            $display("FAIL pause_tick%0d got %h exp %h", i, o0, e);
         end
      end
      apply(0, 1, 0, 0);
      void'(q.pop_front());
      apply(0, 0, 0, 1);
      e = q.pop_front();
      n_tests++;
      if (o0 !== e || e !== {16'h0004, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL pause_resume got %h exp %h", o0, e);
      end
   endtask

   task automatic test_simul();
      logic [17:0] e;
      do_reset();
      apply(0, 1, 0, 0);
      void'(q.pop_front());
      fast(0, 7);
      apply(0, 1, 1, 0);
      e = q.pop_front();
      n_tests++;
      if (o0 !== e || e !== 18'h0) begin
         n_fail++;
         $display("FAIL clr_ss got %h exp %h", o0, e);
      end
      apply(0, 1, 0, 0);
      void'(q.pop_front());
      fast(0, 3);
      apply(0, 0, 1, 1);
      e = q.pop_front();
      n_tests++;
      if (o0 !== e) begin
         n_fail++;
         $display("FAIL clr_tick got %h exp %h", o0, e);
      end
      apply(0, 1, 0, 0);
      void'(q.pop_front());
      apply(0, 1, 0, 1);
      e = q.pop_front();
      n_tests++;
      if (o0 !== e) begin
         n_fail++;
         $display("FAIL ss_tick_run got %h exp %h", o0, e);
      end
      apply(0, 1, 0, 1);
      e = q.pop_front();
      n_tests++;
      if (o0 !== e) begin
         n_fail++;
         $display("FAIL ss_tick_pause got %h exp %h", o0, e);
      end
   endtask

   task automatic test_hold();
      logic [17:0] e;
      do_reset();
      model(0, 1, 0, 0, 1'b1);
      drv(0, 1, 0, 0);
      step();
      step();
      step();
      e = q.pop_front();
      n_tests++;
      if (o0 !== e) begin
         n_fail++;
         $display("FAIL hold_first got %h exp %h", o0, e);
      end
      repeat (1000) step();
      e = mexp(0);
      n_tests++;
      if (o0 !== e) begin
         n_fail++;
         $display("FAIL hold_1000 got %h exp %h", o0, e);
      end
      drv(0, 0, 0, 0);
      step();
      step();
      RESET = 1'b1;
      drv(0, 1, 0, 0);
      step();
      step();
      RESET = 1'b0;
      mreset();
      model(0, 1, 0, 0, 1'b1);
      step();
      step();
      step();
      e = q.pop_front();
      n_tests++;
      if (o0 !== e) begin
         n_fail++;
         $display("FAIL hold_rst got %h exp %h", o0, e);
      end
      repeat (20) step();
      e = mexp(0);
      n_tests++;
      if (o0 !== e) begin
         n_fail++;
         $display("FAIL hold_rst_once got %h exp %h", o0, e);
      end
      drv(0, 0, 0, 0);
      step();
      step();
   endtask

   task automatic test_reset_mid();
      logic [17:0] e;
      do_reset();
      apply(0, 1, 0, 0);
      void'(q.pop_front());
      fast(0, 42);
      e = mexp(0);
      n_tests++;
      if (o0 !== e || e[17:2] !== 16'h0042) begin
         n_fail++;
         $display("FAIL mid_0042 got %h exp %h", o0, e);
      end
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      mreset();
      n_tests++;
      if (o0 !== 18'h0) begin
         n_fail++;
         $display("FAIL mid_reset got %h exp %h", o0, 18'h0);
      end
   endtask

   initial begin
      RESET = 1'b1;
      drv(0, 0, 0, 0);
      drv(1, 0, 0, 0);
      mreset();
      test_reset();
      test_count();
      test_carry();
      test_wrap();
      test_pause();
      test_simul();
      test_hold();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter MAX_MIN, default 59: highest minutes value (legal 1..99) before wrap to 00:00.
REQ-002 sCLK  input  1  system clock; all state updates on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 SLOW_CLK  input  1  divided square wave from the frequency divider; each rising edge is one count tick (1 s nominal).
REQ-005 BTN_SS  input  1  start/stop button, asynchronous level, active-high.
REQ-006 BTN_CLR  input  1  clear button, asynchronous level, active-high.
REQ-007 SEC_ONES  output  4  BCD seconds units, 0..9.
REQ-008 SEC_TENS  output  4  BCD seconds tens, 0..5.
REQ-009 MIN_ONES  output  4  BCD minutes units, 0..9.
REQ-010 MIN_TENS  output  4  BCD minutes tens, 0..9.
REQ-011 RUNNING  output  1  high while FSM is in RUN.
REQ-012 WRAP  output  1  one-cycle pulse on the tick that rolls MAX_MIN:59 to 00:00.

Function
REQ-013 SLOW_CLK, BTN_SS and BTN_CLR each SHALL pass through a 2-flop synchronizer, then a registered rising-edge detector (sync2 high, previous sync2 low) giving a one-sCLK-cycle event.
REQ-014 Latency: input sampled high at sCLK edge n after being low SHALL take effect (digit change, state change) at edge n+2; a held-high input SHALL give exactly one event.
REQ-015 FSM states IDLE, RUN, PAUSE; unused encodings SHALL go to IDLE on the next edge.
REQ-016 SS event: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-017 CLR event: from any state -> IDLE, all digits to 0 on the same edge.
REQ-018 Tick SHALL advance the count only when the current (pre-edge) state is RUN; ticks in IDLE/PAUSE are discarded, not queued.
REQ-019 Count: SEC_ONES 9->0 carries into SEC_TENS; SEC_TENS 5->0 carries into minutes; MIN_ONES 9->0 carries into MIN_TENS; all carries resolve on the same edge.
REQ-020 At minutes==MAX_MIN and seconds==59, a tick SHALL set all digits to 0, pulse WRAP for one cycle, and keep the state RUN.
REQ-021 WRAP SHALL be low in every other cycle.
REQ-022 Simultaneous CLR and SS events: CLR wins, state IDLE, digits 0.
REQ-023 Simultaneous CLR and tick: CLR wins, digits 0, WRAP low.
REQ-024 Simultaneous SS and tick in RUN: tick counted per REQ-018, state becomes PAUSE.
REQ-025 Simultaneous SS and tick in PAUSE: tick discarded, state becomes RUN.
REQ-026 Digits SHALL never hold a non-BCD value or a value above limits (SEC_TENS<=5, minutes<=MAX_MIN).
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 RESET high at a sCLK edge SHALL clear all digits to 0, state to IDLE, RUNNING=0, WRAP=0, and all synchronizer and edge-detect flops to 0.
REQ-029 RESET SHALL take priority over all events; a count in progress when RESET is applied SHALL be lost.
REQ-030 An input held high through reset release SHALL produce one event within 2 edges of release (prev flop cleared); the bench treats this as required behaviour.

Verification
REQ-031 Reset, pulse BTN_SS, apply 5 SLOW_CLK rising edges -> RUNNING=1, digits 00:05, each digit change exactly 2 sCLK edges after SLOW_CLK sampled high.
REQ-032 Preload by ticking to 00:59, one more tick -> 01:00; tick from 09:59 -> 10:00.
REQ-033 MAX_MIN=2, run to 02:59, one tick -> 00:00, WRAP high exactly one cycle, RUNNING stays 1.
REQ-034 RUN at 00:03, BTN_SS pulse, 4 ticks -> remains 00:03, RUNNING=0; BTN_SS again, 1 tick -> 00:04.
REQ-035 BTN_CLR and BTN_SS rising on same edge while RUN at 00:07 -> 00:00, IDLE, RUNNING=0; BTN_CLR coincident with a tick -> 00:00, WRAP=0.
REQ-036 BTN_SS held high 1000 cycles -> single state change; RESET asserted mid-RUN at 00:42 -> next edge 00:00, IDLE, WRAP=0.
